// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (IF) and the data stage (MEM).
// Latency: a request seen in cycle N drives mem_req in N+1. With a zero-wait memory, the stall drops in N+1.
// Backpressure: each requester stalls until its own mem_ack. Data wins ties until fetch has waited STARVE_MAX grants.
//
// Ports:
//   clock, reset_n                      clock and asynchronous active-low reset
//   if_req/if_addr -> if_rdata/if_stall instruction read; if_rdata is valid when if_req & !if_stall
//   d_req/d_we/d_addr/d_wdata           load/store request
//   d_rdata/d_stall                     load data; d_rdata is valid when d_req & !d_stall
//   mem_req/mem_we/mem_addr/mem_wdata   latched request, held until mem_ack
//   mem_rdata/mem_ack                   memory response
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    starve_cnt;

  logic          ack_fetch;
  logic          ack_data;
  logic          arb_en;
  logic          cand_if;
  logic          cand_d;
  logic          grant_d;
  logic          grant_if;

  // A mem_ack only completes an access that is actually in flight.
  assign ack_fetch = (state == FETCH) & mem_ack;
  assign ack_data  = (state == DATA)  & mem_ack;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: arbitrate when idle or on completion.
  // The requester that is finishing is excluded, because its req still shows the old access this cycle.
  always_comb begin
    arb_en    = (state == IDLE) | ack_fetch | ack_data;
    cand_if   = if_req & ~ack_fetch;
    cand_d    = d_req  & ~ack_data;
    grant_d   = arb_en & cand_d & (~cand_if | (starve_cnt < STARVE_LIM));
    grant_if  = arb_en & cand_if & ~grant_d;
    state_nxt = state;
    if (arb_en) begin
      if (grant_d)       state_nxt = DATA;
      else if (grant_if) state_nxt = FETCH;
      else               state_nxt = IDLE;
    end
  end

  // Outputs.
  // A flushed requester (req dropped) sees no stall, while the bus access still runs to its ack.
  always_comb begin
    mem_req  = (state != IDLE);
    if_stall = if_req & ~ack_fetch;
    d_stall  = d_req  & ~ack_data;
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // Latched request and starvation counter.
  // Every data grant made while fetch is asking counts toward forcing a fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      addr_q  <= d_addr;
      we_q    <= d_we;
      wdata_q <= d_wdata;
      if (if_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
    end else if (grant_if) begin
      addr_q     <= if_addr;
      we_q       <= 1'b0;
      starve_cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model.
  // It tracks who owns the port (0 none, 1 fetch, 2 data), the request it presents, and the number of
  // data grants made while fetch was asking.
  int          m_own = 0;
  logic [31:0] m_addr = 0;
  logic        m_we = 0;
  logic [31:0] m_wdata = 0;
  int          m_cnt = 0;
  bit          m_open;
  bit          m_ci;
  bit          m_cd;

  always @(negedge clock) begin
    if (!reset_n) begin
      m_own = 0; m_addr = 0; m_we = 0; m_wdata = 0; m_cnt = 0;
    end
    chk("mem_req", mem_req, m_own != 0);
    if (m_own != 0 || !reset_n) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we || !reset_n) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_stall", if_stall, if_req && !(m_own == 1 && mem_ack));
    chk("d_stall", d_stall, d_req && !(m_own == 2 && mem_ack));
    if (m_own == 1 && mem_ack && if_req) chk("if_rdata", if_rdata, mem_rdata);
    if (m_own == 2 && mem_ack && d_req)  chk("d_rdata", d_rdata, mem_rdata);
    if (reset_n) begin
      m_open = (m_own == 0) || mem_ack;
      m_ci   = if_req && (m_own != 1);
      m_cd   = d_req && (m_own != 2);
      if (m_open) begin
        if (m_cd && (!m_ci || m_cnt < STARVE)) begin
          m_own = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          if (if_req && m_cnt < STARVE) m_cnt++;
        end else if (m_ci) begin
          m_own = 1; m_addr = if_addr; m_we = 0; m_cnt = 0;
        end else begin
          m_own = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  bit i_done;
  bit d_done;

  initial begin
    reset_n = 0; if_req = 1; if_addr = 32'h40; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; mem_rdata = 0; mem_ack = 0;
    step(); step();
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_stall", if_stall, 1'b1);
    step();
    reset_n = 1; if_req = 0;

    // Single fetch; the memory acks two cycles after mem_req rises.
    step(); if_req = 1; if_addr = 32'h100;
    #1; chk("f_stall0", if_stall, 1'b1); chk("f_req0", mem_req, 1'b0);
    step(); #1; chk("f_req1", mem_req, 1'b1); chk("f_addr", mem_addr, 32'h100);
    chk("f_we", mem_we, 1'b0); chk("f_stall1", if_stall, 1'b1);
    step(); #1; chk("f_stall2", if_stall, 1'b1);
    step(); mem_ack = 1; mem_rdata = 32'h8C220004;
    #1; chk("f_stall_ack", if_stall, 1'b0); chk("f_rdata", if_rdata, 32'h8C220004);
    step(); if_req = 0; mem_ack = 0; #1; chk("f_idle", mem_req, 1'b0);

    // Store with a zero-wait ack.
    step(); d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    #1; chk("s_stall0", d_stall, 1'b1);
    step(); mem_ack = 1;
    #1; chk("s_req", mem_req, 1'b1); chk("s_we", mem_we, 1'b1);
    chk("s_addr", mem_addr, 32'h2000); chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    chk("s_stall_ack", d_stall, 1'b0);
    step(); d_req = 0; d_we = 0; mem_ack = 0; #1; chk("s_idle", mem_req, 1'b0);

    // Conflict: data first, then fetch back-to-back.
    step(); if_req = 1; if_addr = 32'h300; d_req = 1; d_addr = 32'h400;
    step(); #1; chk("c_addr_d", mem_addr, 32'h400);
    mem_ack = 1; mem_rdata = 32'h11;
    #1; chk("c_dstall", d_stall, 1'b0); chk("c_istall", if_stall, 1'b1);
    chk("c_drdata", d_rdata, 32'h11);
    step(); d_req = 0; mem_ack = 0;
    #1; chk("c_b2b_req", mem_req, 1'b1); chk("c_addr_f", mem_addr, 32'h300);
    chk("c_istall2", if_stall, 1'b1);
    step(); mem_ack = 1; #1; chk("c_istall_ack", if_stall, 1'b0);
    step(); if_req = 0; mem_ack = 0; #1; chk("c_idle", mem_req, 1'b0);

    // Flush: fetch dropped in flight, pending data granted in the fetch ack cycle.
    step(); if_req = 1; if_addr = 32'h500;
    step(); if_req = 0; d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h1234;
    #1; chk("fl_req", mem_req, 1'b1); chk("fl_addr", mem_addr, 32'h500);
    chk("fl_istall", if_stall, 1'b0); chk("fl_dstall", d_stall, 1'b1);
    step(); #1; chk("fl_req2", mem_req, 1'b1);
    step(); mem_ack = 1; #1; chk("fl_dstall_ack", d_stall, 1'b1);
    step(); mem_ack = 0; #1; chk("fl_addr_d", mem_addr, 32'h600); chk("fl_we_d", mem_we, 1'b1);
    step(); mem_ack = 1; #1; chk("fl_dstall_done", d_stall, 1'b0);
    step(); d_req = 0; d_we = 0; mem_ack = 0;

    // Reset mid-access, then a stray ack right after release.
    step(); d_req = 1; d_addr = 32'h700;
    step(); #1; chk("r_req", mem_req, 1'b1);
    reset_n = 0; #1; chk("r_req_async", mem_req, 1'b0); chk("r_dstall", d_stall, 1'b1);
    step(); reset_n = 1; mem_ack = 1;
    #1; chk("r_stray_stall", d_stall, 1'b1); chk("r_stray_req", mem_req, 1'b0);
    step(); mem_ack = 0; #1; chk("r_regrant", mem_addr, 32'h700);
    step(); mem_ack = 1;
    step(); d_req = 0; mem_ack = 0;

    // Starvation: four data grants while fetch asks (fetch flushed each time), then fetch must win.
    for (int i = 0; i < STARVE; i++) begin
      step(); if_req = 1; if_addr = 32'h800; d_req = 1; d_addr = 32'h900 + 32'(i * 4);
      step(); #1; chk("sv_data", mem_addr, 32'h900 + 32'(i * 4));
      if_req = 0; mem_ack = 1;
      step(); d_req = 0; mem_ack = 0;
    end
    step(); if_req = 1; d_req = 1; d_addr = 32'hA00;
    step(); #1; chk("sv_fetch_wins", mem_addr, 32'h800);
    mem_ack = 1;
    step(); if_req = 0; mem_ack = 0; #1; chk("sv_data_after", mem_addr, 32'hA00);
    mem_ack = 1;
    step(); d_req = 0; mem_ack = 0;

    // Randomized traffic with flushes, variable ack latency, stray acks and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      i_done = if_req && !if_stall;
      d_done = d_req && !d_stall;
      @(posedge clock); #1;
      if (!if_req || i_done) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
      if (!d_req || d_done) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1);
        d_addr = $urandom; d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      mem_ack   = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
      reset_n   = ($urandom_range(0, 299) != 0);
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single unified memory port between the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Latches the winning request, holds it on the memory bus until mem_ack, and returns read data.
- Generates per-stage stall signals, which the pipeline control ORs with the interlock stall.
- Gives data priority (older instruction) and uses a starvation counter so fetch always makes progress.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, max consecutive data grants while a fetch is pending before fetch is forced to win (1..15)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
if_req  input  1  IF stage requests instruction read; held until if_stall low
if_addr  input  AW  fetch address (PC)
if_rdata  output  DW  instruction word; valid in cycle if_req=1 and if_stall=0
if_stall  output  1  IF must hold
d_req  input  1  MEM stage requests access; held until d_stall low
d_we  input  1  1=store, 0=load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_rdata  output  DW  load data; valid in cycle d_req=1 and d_stall=0
d_stall  output  1  MEM (and older stages) must hold
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid with mem_ack
mem_ack  input  1  one-cycle completion pulse; only meaningful while mem_req=1

Behaviour:
- FSM states: IDLE, FETCH, DATA. The state register, latched addr/we/wdata registers and starve_cnt are clocked on the rising edge of clock.
- Reset (reset_n=0, takes effect immediately): state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Outputs with reset_n=0: if_stall=if_req, d_stall=d_req.
  - Reset mid-transaction abandons the access; a late mem_ack after reset is ignored.
- mem_req=1 iff state!=IDLE. mem_we/mem_addr/mem_wdata come from the latched registers and are stable for the whole request.
- Fetches always have mem_we=0.
- Arbitration is evaluated in IDLE, and in the ack cycle of FETCH/DATA over the other requester only:
  - pick DATA if d_req and (!if_req or starve_cnt<STARVE_MAX);
  - else pick FETCH if if_req;
  - else go to IDLE.
- On a grant, latch the requester's addr/we/wdata and move to the granted state next cycle.
- Back-to-back: in an ack cycle the finished requester is excluded from arbitration, because it advances that cycle and presents a new request next cycle. The other requester may be granted in the same cycle, with no idle gap.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on each DATA grant made while if_req=1;
  - clears on each FETCH grant;
  - unchanged otherwise.
- Stalls (combinational):
  - if_stall = if_req & !(state==FETCH & mem_ack)
  - d_stall = d_req & !(state==DATA & mem_ack)
- Read data: if_rdata=mem_rdata and d_rdata=mem_rdata, pass-through. Each is valid only in its own ack cycle; the consumer captures it on that edge.
- Minimum latency with zero-wait memory (ack in first mem_req cycle): request seen in cycle N, mem_req in N+1, stall low in N+1, i.e. 2 cycles per access.
- Ack timing rules:
  - mem_ack while state==IDLE is ignored.
  - A requester dropping its req while its access is in flight (pipeline flush) does not abort the access. The FSM waits for mem_ack, discards the data, and no stall is reported for a deasserted req.
- Simultaneous if_req and d_req in IDLE with starve_cnt<STARVE_MAX: data wins, fetch stalls.

Test Plan:
- Single fetch: if_req=1, addr 0x100, memory acks 2 cycles after mem_req rises, returns 0x8C220004 -> mem_req 0→1 the next cycle with mem_addr=0x100, mem_we=0; if_stall=1 until the ack cycle; if_rdata=0x8C220004 with if_stall=0 in that cycle.
- Store: d_req=1, d_we=1, addr 0x2000, wdata 0xDEADBEEF, zero-wait ack -> one cycle of mem_req with mem_we=1, addr 0x2000, wdata 0xDEADBEEF; d_stall low in the ack cycle.
- Conflict: if_req and d_req both asserted from IDLE -> DATA is granted first. In the DATA ack cycle FETCH is granted back-to-back (no IDLE cycle), and if_stall stays high until the fetch ack.
- Starvation: if_req held high, d_req re-asserted after every data completion, STARVE_MAX=4 -> exactly 4 DATA grants, then a FETCH grant; starve_cnt returns to 0.
- Reset mid-access: reset_n low during DATA with mem_req=1 -> mem_req=0 immediately, state IDLE, starve_cnt=0. After release, a stray mem_ack produces no stall release.
- Flush: if_req dropped while FETCH is outstanding -> mem_req held until mem_ack, if_stall=0 throughout; a pending d_req is granted in the ack cycle.
